// File: rtl/cordic_hyp_pkg.sv
// rtl/cordic_hyp_pkg.sv - states, fixed-point constants and step-sequence helpers for the hyperbolic CORDIC
package cordic_hyp_pkg;

   typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_ROT, ST_FINAL, ST_DONE} state_e;

   // 1/K_h with indices 4 and 13 repeated, Q2.62
   localparam logic [63:0]        INV_KH_Q62   = 64'h4D47_A1C8_03BB_1000;
   localparam logic signed [63:0] LN_TMIN_Q56  = (64'sd107 <<< 56) / 64'sd1000;
   localparam logic signed [63:0] LN_TMAX_Q56  = ((64'sd958 <<< 53) / 64'sd100) <<< 3;
   localparam logic signed [63:0] EXP_TMAX_Q56 = ((64'sd1118 <<< 52) / 64'sd1000) <<< 4;

   // atanh(2^-i) in Q2.62, summed from the odd power series 2^-ik / k
   function automatic logic [63:0] atanh_q62(input int i);
      logic [63:0] acc;
      acc = '0;
      for (int k = 1; i * k < 62; k += 2)
         acc += (64'h4000_0000_0000_0000 >> (i * k)) / 64'(k);
      return acc;
   endfunction

   function automatic int n_steps(input int iter);
      return iter + 1 + ((iter >= 13) ? 1 : 0);
   endfunction

   // step counter -> shift index, with 4 and 13 each taken twice
   function automatic logic [4:0] shift_of(input logic [4:0] cnt, input int iter);
      int s;
      s = int'(cnt) + 1;
      if (cnt >= 5'd4) s = s - 1;
      if (iter >= 13 && cnt >= 5'd14) s = s - 1;
      return 5'(s);
   endfunction

endpackage

// File: rtl/cordic_hyp_step.sv
// rtl/cordic_hyp_step.sv - one combinational hyperbolic micro-rotation on W+2 bit operands
module cordic_hyp_step
   import cordic_hyp_pkg::*;
#(
   parameter int W    = 32,
   parameter int FRAC = 24
) (
   input  logic signed [W+1:0] x_i,
   input  logic signed [W+1:0] y_i,
   input  logic signed [W+1:0] z_i,
   input  logic        [4:0]   shift_i,
   input  logic                mode_i,
   output logic signed [W+1:0] x_o,
   output logic signed [W+1:0] y_o,
   output logic signed [W+1:0] z_o
);
   localparam int DW = W + 2;
   localparam int GF = FRAC + 2;

   logic signed [DW-1:0] atanh_tab [32];

   for (genvar g = 0; g < 32; g++) begin : g_tab
      if (g >= 1 && g <= 30) begin : g_val
         assign atanh_tab[g] = DW'(atanh_q62(g) >> (62 - GF));
      end else begin : g_zero
         assign atanh_tab[g] = '0;
      end
   end

   logic                 pos;
   logic signed [DW-1:0] x_sh;
   logic signed [DW-1:0] y_sh;

   // LN drives y to zero, EXP drives z to zero
   always_comb begin
      pos  = mode_i ? ~z_i[DW-1] : y_i[DW-1];
      x_sh = x_i >>> shift_i;
      y_sh = y_i >>> shift_i;
      if (pos) begin
         x_o = x_i + y_sh;
         y_o = y_i + x_sh;
         z_o = z_i - atanh_tab[shift_i];
      end else begin
         x_o = x_i - y_sh;
         y_o = y_i - x_sh;
         z_o = z_i + atanh_tab[shift_i];
      end
   end

endmodule

// File: rtl/cordic_hyp_engine.sv
// rtl/cordic_hyp_engine.sv - iterative hyperbolic CORDIC computing ln(T) or exp(T)
// CORDIC_ROUND_EN: round-to-nearest (ties away) when dropping guard bits, else floor
module cordic_hyp_engine
   import cordic_hyp_pkg::*;
#(
   parameter int W    = 32,
   parameter int FRAC = 24,
   parameter int ITER = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         rst_fsm_i,
   input  logic         begin_i,
   input  logic         mode_i,
   input  logic [W-1:0] t_i,
   output logic         busy_o,
   output logic         ack_o,
   output logic         o_f_o,
   output logic         u_f_o,
   output logic [W-1:0] result_o
);
   localparam int DW = W + 2;
   localparam int GF = FRAC + 2;
   localparam int NS = n_steps(ITER);

   localparam logic signed [DW-1:0] ONE_G      = DW'(64'd1 << GF);
   localparam logic signed [DW-1:0] INV_KH_G   = DW'(INV_KH_Q62 >> (62 - GF));
   localparam logic signed [63:0]   LN_TMIN_F  = LN_TMIN_Q56 >>> (56 - FRAC);
   localparam logic signed [63:0]   LN_TMAX_F  = LN_TMAX_Q56 >>> (56 - FRAC);
   localparam logic signed [63:0]   EXP_TMAX_F = EXP_TMAX_Q56 >>> (56 - FRAC);
   localparam logic [W-1:0]         RES_MAX    = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]         RES_MIN    = {1'b1, {(W-1){1'b0}}};

   state_e               state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic signed [DW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic                 mode_q, mode_d;
   logic [W-1:0]         t_q, t_d;
   logic                 o_f_q, o_f_d, u_f_q, u_f_d;
   logic [W-1:0]         result_q, result_d;

   logic signed [DW-1:0] x_s, y_s, z_s;
   logic signed [DW-1:0] t_g;
   logic signed [63:0]   t64;
   logic                 ovf, unf;
   logic signed [DW:0]   pre;
   logic signed [DW+1:0] adj, sh;
   logic [W-1:0]         sat;

   cordic_hyp_step #(.W(W), .FRAC(FRAC)) u_step (
      .x_i     (x_q),
      .y_i     (y_q),
      .z_i     (z_q),
      .shift_i (shift_of(cnt_q, ITER)),
      .mode_i  (mode_q),
      .x_o     (x_s),
      .y_o     (y_s),
      .z_o     (z_s)
   );

   always_comb begin
      t_g = {t_q, 2'b00};
      t64 = {{(64-W){t_q[W-1]}}, t_q};
      ovf = 1'b0;
      unf = 1'b0;
      if (!mode_q) begin
         unf = (t64 <= 64'sd0) || (t64 < LN_TMIN_F);
         ovf = t64 > LN_TMAX_F;
      end else begin
         ovf = t64 > EXP_TMAX_F;
         unf = t64 < -EXP_TMAX_F;
      end
   end

   // guard bits are fractional: drop two, then clamp to W bits
   always_comb begin
      pre = mode_q ? ({x_q[DW-1], x_q} + {y_q[DW-1], y_q}) : {z_q, 1'b0};
`ifdef CORDIC_ROUND_EN
      adj = {pre[DW], pre} + (pre[DW] ? (DW+2)'(1) : (DW+2)'(2));
`else
      adj = {pre[DW], pre};
`endif
      sh = adj >>> 2;
      if (sh[DW+1:W-1] == '0 || sh[DW+1:W-1] == '1) sat = sh[W-1:0];
      else                                         sat = sh[DW+1] ? RES_MIN : RES_MAX;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      z_d      = z_q;
      mode_d   = mode_q;
      t_d      = t_q;
      o_f_d    = o_f_q;
      u_f_d    = u_f_q;
      result_d = result_q;
      if (rst_fsm_i) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         o_f_d    = 1'b0;
         u_f_d    = 1'b0;
         result_d = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (begin_i) begin
               state_d = ST_INIT;
               mode_d  = mode_i;
               t_d     = t_i;
               o_f_d   = 1'b0;
               u_f_d   = 1'b0;
            end
            ST_INIT: begin
               cnt_d = '0;
               if (!mode_q) begin
                  x_d = t_g + ONE_G;
                  y_d = t_g - ONE_G;
                  z_d = '0;
               end else begin
                  x_d = INV_KH_G;
                  y_d = '0;
                  z_d = t_g;
               end
               o_f_d   = ovf;
               u_f_d   = unf;
               state_d = (ovf || unf) ? ST_FINAL : ST_ROT;
            end
            ST_ROT: begin
               x_d   = x_s;
               y_d   = y_s;
               z_d   = z_s;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'(NS - 1)) state_d = ST_FINAL;
            end
            ST_FINAL: begin
               if (o_f_q)      result_d = RES_MAX;
               else if (u_f_q) result_d = mode_q ? '0 : RES_MIN;
               else            result_d = sat;
               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         mode_q   <= 1'b0;
         t_q      <= '0;
         o_f_q    <= 1'b0;
         u_f_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         mode_q   <= mode_d;
         t_q      <= t_d;
         o_f_q    <= o_f_d;
         u_f_q    <= u_f_d;
         result_q <= result_d;
      end
   end

   assign busy_o   = (state_q == ST_INIT) || (state_q == ST_ROT) || (state_q == ST_FINAL);
   assign ack_o    = (state_q == ST_DONE);
   assign o_f_o    = o_f_q;
   assign u_f_o    = u_f_q;
   assign result_o = result_q;

endmodule

// File: doc/cordic_hyp_engine.md
CORDIC_HYP_ENGINE -- requirements
Module: cordic_hyp_engine

Interface
REQ-001 Parameter W, default 32: data width in bits, two's complement, range 16..48.
REQ-002 Parameter FRAC, default 24: fraction bits of T and RESULT; FRAC SHALL be in 8..W-4.
REQ-003 Parameter ITER, default 16: CORDIC shift indices 1..ITER, range 8..30.
REQ-004 CLK  in  1  system clock, all state on rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 RST_FSM  in  1  synchronous soft reset; FSM to IDLE, outputs cleared.
REQ-007 BEGIN  in  1  start request, sampled only in IDLE or DONE.
REQ-008 MODE  in  1  0 = LN (vectoring), 1 = EXP (rotation); sampled with BEGIN.
REQ-009 T  in  W  argument, signed Q(W-FRAC).FRAC; sampled with BEGIN.
REQ-010 BUSY  out  1  high in INIT, ROT and FINAL.
REQ-011 ACK  out  1  calculation complete; level, held in DONE.
REQ-012 O_F  out  1  argument above convergence domain; RESULT saturated.
REQ-013 U_F  out  1  argument below domain (LN: T<=0 or T<LN_TMIN; EXP: T<-EXP_TMAX).
REQ-014 RESULT  out  W  signed Q(W-FRAC).FRAC; valid while ACK high.

Function
REQ-015 FSM states: IDLE, INIT, ROT, FINAL, DONE.
- IDLE/DONE + BEGIN -> INIT.
- INIT -> ROT.
- ROT -> FINAL after the last step.
- FINAL -> DONE.
- DONE holds until BEGIN or RST_FSM.
REQ-016 Step sequence i = 1..ITER, with indices 4 and 13 each executed twice when they are <= ITER; N_STEPS = ITER + repeats, 18 at defaults.
REQ-017 One micro-rotation per cycle in ROT: x' = x + d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*ATANH[i].
REQ-018 Direction d: LN uses d = -sign(y) (y driven to 0); EXP uses d = sign(z) (z driven to 0).
REQ-019 INIT loads:
- LN: x = T+1.0, y = T-1.0, z = 0.
- EXP: x = 1/K_h, y = 0, z = T.
REQ-020 FINAL computes RESULT: LN = 2*z (left shift by 1); EXP = x+y.
REQ-021 Datapath registers are W+2 bits (2 guard bits); the final value SHALL saturate to W bits.
REQ-022 Domain check happens in INIT.
- LN: T<=0 -> U_F=1, RESULT = most-negative.
- LN: 0<T<LN_TMIN -> U_F=1, RESULT = most-negative.
- LN: T>LN_TMAX -> O_F=1, RESULT = most-positive.
- EXP: T>EXP_TMAX -> O_F=1, RESULT = most-positive.
- EXP: T<-EXP_TMAX -> U_F=1, RESULT = 0.
- Every out-of-domain case skips ROT and goes to FINAL.
REQ-023 Latency: ACK SHALL rise N_STEPS+2 edges after the edge that samples BEGIN (20 at defaults); out-of-domain arguments give 2 edges.
REQ-024 BEGIN while BUSY is ignored; T and MODE are not resampled.
REQ-025 BEGIN in DONE clears ACK, O_F and U_F on the same edge it enters INIT.
REQ-026 Accuracy: in-domain |error| <= 2^-(ITER-3) in real units.

Reset
REQ-027 RST_N low SHALL immediately force: state IDLE, ACK=0, BUSY=0, O_F=0, U_F=0, RESULT=0, step counter 0, x/y/z=0.
REQ-028 RST_N or RST_FSM asserted during ROT aborts the calculation; no ACK is produced for it.
REQ-029 RST_N has priority over RST_FSM; RST_FSM has priority over BEGIN.

Configuration
REQ-030 Macro CORDIC_ROUND_EN controls how FINAL drops the guard bits.
- Defined: round-to-nearest, ties away from zero, then saturate.
- Undefined: truncate toward minus infinity, then saturate.
- Latency is identical in both cases.

Structure
REQ-031 Package cordic_hyp_pkg holds:
- state enum;
- ATANH table, atanh(2^-i) for i = 1..30, Q2.62;
- 1/K_h in Q2.62;
- LN_TMIN = 0.107, LN_TMAX = 9.58, EXP_TMAX = 1.118, all Q8.56;
- the constants above are right-shifted to FRAC at elaboration.
REQ-032 Sub-module cordic_hyp_step: combinational one-iteration datapath (x, y, z, shift index, mode) -> (x', y', z'), instantiated once; the FSM and counter stay in the top.

Verification
REQ-033 LN, T = 0x01000000 (1.0) -> ACK after 20 cycles, RESULT = 0 +/-2048 LSB, O_F = U_F = 0.
REQ-034 LN, T = 0x02B7E151 (e) -> RESULT = 0x01000000 +/-2048 LSB.
REQ-035 EXP, T = 0x01000000 -> RESULT = 0x02B7E151 +/-2048 LSB; EXP, T = 0 -> RESULT = 0x01000000 +/-2048 LSB.
REQ-036 LN, T = 0 -> U_F = 1, RESULT = 0x80000000, ACK after 2 cycles; LN, T = 0x10000000 (16.0) -> O_F = 1, RESULT = 0x7FFFFFFF.
REQ-037 BEGIN pulsed again at ROT step 5 -> ignored, original result returned. RST_N low at step 10 -> all outputs 0 asynchronously; the next BEGIN completes normally.
REQ-038 LN, T = 0x01800000 (1.5) with and without CORDIC_ROUND_EN -> the two results differ by at most 1 LSB; both meet REQ-026.
